// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM encoding and default width.
package cmp_pkg;

  localparam int CMP_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } cmp_state_e;

endpackage

// File: rtl/comparator_1bit.sv
// Single-bit magnitude comparator cell: exactly one of E/G/L is high for any input pair.
module comparator_1bit (
  input  logic A,
  input  logic B,
  output logic E,
  output logic G,
  output logic L
);

  assign E = ~(A ^ B);
  assign G = A & ~B;
  assign L = ~A & B;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// MSB-first bit-serial comparison of two latched operands using one comparator cell,
// exiting at the first differing bit and reporting through a start/done handshake.
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CW-1:0]    steps
);

  localparam int IW = $clog2(WIDTH);

  cmp_state_e       r_state;
  cmp_state_e       w_state_nxt;
  logic             w_accept;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_steps;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;
  logic             w_bit_a;
  logic             w_bit_b;
  logic             w_e;
  logic             w_g;
  logic             w_l;
  logic             w_last;

  assign w_bit_a = r_a[r_idx];
  assign w_bit_b = r_b[r_idx];
  assign w_last  = (r_idx == '0);

  comparator_1bit u_cmp (
    .A (w_bit_a),
    .B (w_bit_b),
    .E (w_e),
    .G (w_g),
    .L (w_l)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (w_g || w_l || (w_e && w_last)) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_steps <= '0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx   <= IW'(WIDTH - 1);
        r_steps <= '0;
        r_eq    <= 1'b0;
        r_gt    <= 1'b0;
        r_lt    <= 1'b0;
      end else if (r_state == SCAN) begin
        r_steps <= r_steps + CW'(1);
        if (w_g)                 r_gt  <= 1'b1;
        else if (w_l)            r_lt  <= 1'b1;
        else if (w_e && w_last)  r_eq  <= 1'b1;
        else                     r_idx <= r_idx - IW'(1);
      end
    end
  end

  // Operands are pure data: captured only on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
  assign eq    = r_eq;
  assign gt    = r_gt;
  assign lt    = r_lt;
  assign steps = r_steps;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl (WIDTH=8) with hand-computed expectations.
module tb_serial_cmp_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       eq;
  logic       gt;
  logic       lt;
  logic [3:0] steps;

  int tests;
  int fails;

  serial_cmp_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt),
    .steps (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy"},  {31'd0, busy}, 32'd0);
    chk({tag, ".done"},  {31'd0, done}, 32'd0);
    chk({tag, ".eq"},    {31'd0, eq},   32'd0);
    chk({tag, ".gt"},    {31'd0, gt},   32'd0);
    chk({tag, ".lt"},    {31'd0, lt},   32'd0);
    chk({tag, ".steps"}, {28'd0, steps}, 32'd0);
  endtask

  task automatic chk_result(input string tag, input logic e_eq, input logic e_gt,
                            input logic e_lt, input int e_steps);
    chk({tag, ".eq"},    {31'd0, eq},    {31'd0, e_eq});
    chk({tag, ".gt"},    {31'd0, gt},    {31'd0, e_gt});
    chk({tag, ".lt"},    {31'd0, lt},    {31'd0, e_lt});
    chk({tag, ".steps"}, {28'd0, steps}, 32'(e_steps));
  endtask

  // Entered in cycle 0; leaves the bench in cycle d+2 with start low.
  // glitch > 0 pulses start with new operands in that busy cycle.
  task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input int d, input logic e_eq, input logic e_gt, input logic e_lt,
                         input int glitch);
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= d; c++) begin
      chk($sformatf("%s.scan%0d.busy", tag, c), {31'd0, busy}, 32'd1);
      chk($sformatf("%s.scan%0d.done", tag, c), {31'd0, done}, 32'd0);
      if (c == glitch) begin
        start = 1'b1;
        a = 8'h01;
        b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    chk_result(tag, e_eq, e_gt, e_lt, d);
    tick();
    chk({tag, ".after.done"}, {31'd0, done}, 32'd0);
    chk({tag, ".after.busy"}, {31'd0, busy}, 32'd0);
    chk_result({tag, ".hold"}, e_eq, e_gt, e_lt, d);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    tick();
    tick();
    chk_idle_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_idle_zero("post_reset");

    run_cmp("eq_5A",  8'h5A, 8'h5A, 8, 1'b1, 1'b0, 1'b0, 0);
    run_cmp("gt_msb", 8'h80, 8'h7F, 1, 1'b0, 1'b1, 1'b0, 0);
    run_cmp("lt_lsb", 8'h12, 8'h13, 8, 1'b0, 1'b0, 1'b1, 0);
    run_cmp("eq_00",  8'h00, 8'h00, 8, 1'b1, 1'b0, 1'b0, 0);
    run_cmp("ignore", 8'h40, 8'h20, 2, 1'b0, 1'b1, 1'b0, 1);
    tick();
    chk("ignore.stay_idle", {31'd0, busy}, 32'd0);

    // Abort mid-scan: reset sampled at the end of cycle 4.
    a = 8'h0F;
    b = 8'h0E;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort.c4.busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk_idle_zero("abort.c5");
    rst_n = 1'b1;
    tick();
    chk_idle_zero("abort.c6");
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort.nodone%0d", c), {31'd0, done}, 32'd0);
      tick();
    end
    run_cmp("refresh", 8'h0F, 8'h0E, 8, 1'b0, 1'b1, 1'b0, 0);

    // Reset and start on the same edge: reset wins.
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    tick();
    chk_idle_zero("rst_vs_start");
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk("rst_vs_start.idle", {31'd0, busy}, 32'd0);

    // start held high: acceptances at cycles 0 and 4, done at 3 and 7.
    a = 8'hC0;
    b = 8'h80;
    start = 1'b1;
    tick();
    chk("held.c1.busy", {31'd0, busy}, 32'd1);
    tick();
    chk("held.c2.done", {31'd0, done}, 32'd0);
    tick();
    chk("held.c3.done", {31'd0, done}, 32'd1);
    chk_result("held.c3", 1'b0, 1'b1, 1'b0, 2);
    tick();
    chk("held.c4.busy", {31'd0, busy}, 32'd0);
    chk("held.c4.done", {31'd0, done}, 32'd0);
    tick();
    chk("held.c5.busy", {31'd0, busy}, 32'd1);
    chk("held.c5.steps", {28'd0, steps}, 32'd0);
    tick();
    chk("held.c6.done", {31'd0, done}, 32'd0);
    tick();
    chk("held.c7.done", {31'd0, done}, 32'd1);
    chk_result("held.c7", 1'b0, 1'b1, 1'b0, 2);
    start = 1'b0;
    tick();
    chk("held.c8.busy", {31'd0, busy}, 32'd0);
    tick();
    chk("held.c9.busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
